mont_domain_conv: RTL



---
 rtl/mont_pkg.sv | 17 +
 rtl/mont_conv_step.sv | 31 +++
 rtl/mont_domain_conv.sv | 119 +++++++++++
 3 files changed

// File: rtl/mont_pkg.sv
// Shared types and widths for the Montgomery domain converter.
package mont_pkg;

  localparam int unsigned MONT_W = 256;

  typedef enum logic {
    CONV_TO   = 1'b0,
    CONV_FROM = 1'b1
  } conv_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } conv_state_e;

endpackage

// File: rtl/mont_conv_step.sv
// One iteration of the domain conversion: double-and-reduce (TO) or add-and-halve (FROM).
module mont_conv_step
  import mont_pkg::*;
#(
  parameter int unsigned W = MONT_W
) (
  input  conv_mode_e   mode,
  input  logic [W:0]   t,
  input  logic [W-1:0] p,
  output logic [W:0]   t_next
);

  logic [W:0] p_ext;
  logic [W:0] dbl;
  logic [W:0] dbl_sub;
  logic [W:0] half_sum;

  always_comb begin
    p_ext    = {1'b0, p};
    // t < p always holds, so t[W] is zero and 2t fits in W+1 bits
    dbl      = {t[W-1:0], 1'b0};
    dbl_sub  = dbl - p_ext;
    half_sum = t + (t[0] ? p_ext : '0);
    if (mode == CONV_TO) begin
      t_next = (dbl >= p_ext) ? dbl_sub : dbl;
    end else begin
      t_next = {1'b0, half_sum[W:1]};
    end
  end

endmodule

// File: rtl/mont_domain_conv.sv
// Bit-serial Montgomery domain converter: Y = X*2^W mod P (TO) or X*2^-W mod P (FROM).
module mont_domain_conv
  import mont_pkg::*;
#(
  parameter int unsigned W = MONT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] X,
  input  logic [W-1:0] P,
  output logic [W-1:0] Y,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  conv_state_e  state_q, state_d;
  conv_mode_e   mode_q, mode_d;
  logic [W-1:0] p_q, p_d;
  logic [W:0]   t_q, t_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] y_q, y_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic [W:0]   t_next;

  mont_conv_step #(.W(W)) u_step (
    .mode   (mode_q),
    .t      (t_q),
    .p      (p_q),
    .t_next (t_next)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    p_d     = p_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = conv_mode_e'(mode);
          p_d    = P;
          t_d    = {1'b0, X};
          cnt_d  = '0;
          busy_d = 1'b1;
          if ((P == '0) || (X >= P) || (mode && !P[0])) begin
            y_d     = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        t_d   = t_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          y_d     = t_next[W-1:0];
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // Error path enters DONE without a pulse; it is issued one cycle later.
        if (done_q) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= CONV_TO;
      p_q     <= '0;
      t_q     <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      p_q     <= p_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Y    = y_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
